// File: rtl/up_dn_counter_driver_if.sv
// rtl/up_dn_counter_driver_if.sv - request and counter-command signal bundle for up_dn_counter_driver
interface up_dn_counter_driver_if #(
  parameter int WIDTH = 5
);
  // request side
  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic [WIDTH-1:0] req_base;
  logic [WIDTH-1:0] req_target;
  // counter command side
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_load;
  logic             cnt_up;
  logic             cnt_down;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_high;
  logic             cnt_low;
  // status
  logic             busy;
  logic             done;
  logic             err;
  logic [5:0]       steps;

  // driver view
  modport slave (
    input  req_valid, req_load, req_base, req_target,
    input  cnt_value, cnt_high, cnt_low,
    output req_ready, cnt_in, cnt_load, cnt_up, cnt_down,
    output busy, done, err, steps
  );

  // request source / counter view
  modport master (
    output req_valid, req_load, req_base, req_target,
    output cnt_value, cnt_high, cnt_low,
    input  req_ready, cnt_in, cnt_load, cnt_up, cnt_down,
    input  busy, done, err, steps
  );
endinterface

// File: rtl/up_dn_counter_driver.sv
// rtl/up_dn_counter_driver.sv - steps a saturating up/down counter to a requested target
module up_dn_counter_driver #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  up_dn_counter_driver_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    STEP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] base_r;
  logic             load_r;
  logic [5:0]       steps_r;
  logic [TW-1:0]    timer;

  logic need_up;
  logic need_down;
  logic at_target;
  logic step_fault;

  // Direction is taken live from the counter output, so the counter must be registered.
  assign need_up    = (bus.cnt_value < target_r);
  assign need_down  = (bus.cnt_value > target_r);
  assign at_target  = (bus.cnt_value == target_r);
  assign step_fault = (need_up && bus.cnt_high) ||
                      (need_down && bus.cnt_low) ||
                      (timer == TW'(TIMEOUT));

  // Command and status outputs decode the state register; reset drops them at once.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.cnt_in    = base_r;
  assign bus.cnt_load  = (state == LOAD) && load_r;
  assign bus.cnt_up    = (state == STEP) && need_up;
  assign bus.cnt_down  = (state == STEP) && need_down;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == ERR);
  assign bus.steps     = steps_r;

  // Request capture, load/step sequencing, step counting and timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target_r <= '0;
      base_r   <= '0;
      load_r   <= 1'b0;
      steps_r  <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            target_r <= bus.req_target;
            base_r   <= bus.req_base;
            load_r   <= bus.req_load;
            steps_r  <= '0;
            timer    <= '0;
            state    <= bus.req_load ? LOAD : STEP;
          end
        end
        LOAD: begin
          state <= STEP;
        end
        STEP: begin
          // Reaching the target takes priority over any fault seen on the same edge.
          if (at_target) begin
            state <= DONE;
          end else if (step_fault) begin
            state <= ERR;
          end else if (need_up || need_down) begin
            if (steps_r != 6'd63) begin
              steps_r <= steps_r + 6'd1;
            end
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_dn_counter_driver.sv
// tb/tb_up_dn_counter_driver.sv - scoreboard bench for up_dn_counter_driver with a 5-bit counter model
module tb_up_dn_counter_driver;

  typedef struct {
    logic       is_err;
    int         steps;
    logic [4:0] value;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  logic [4:0] ctr;
  logic       stuck_en;
  logic [4:0] stuck_val;
  logic       force_high;

  up_dn_counter_driver_if #(.WIDTH(5)) bus ();

  up_dn_counter_driver #(.WIDTH(5), .TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Saturating counter model: load beats down, down beats up; no reset of its own.
  always @(posedge clk) begin
    if (bus.cnt_load)
      ctr <= bus.cnt_in;
    else if (bus.cnt_down && ctr != 5'd0)
      ctr <= ctr - 5'd1;
    else if (bus.cnt_up && ctr != 5'd31)
      ctr <= ctr + 5'd1;
  end

  assign bus.cnt_value = stuck_en ? stuck_val : ctr;
  assign bus.cnt_high  = force_high || (bus.cnt_value == 5'd31);
  assign bus.cnt_low   = (bus.cnt_value == 5'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run_req(input string name, input logic ld, input logic [4:0] base,
                         input logic [4:0] tgt, input logic e_err, input int e_steps,
                         input logic [4:0] e_val, output int lat, output int ups,
                         output int downs, output int loads);
    exp_t e;
    exp_t got_e;
    bit   got;
    int   guard;
    e.is_err = e_err;
    e.steps  = e_steps;
    e.value  = e_val;
    sb.push_back(e);
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_base   = base;
    bus.req_target = tgt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; ups = 0; downs = 0; loads = 0; got = 0;
    while (lat < 200) begin
      if (bus.done || bus.err) begin
        got = 1;
        break;
      end
      ups   += int'(bus.cnt_up);
      downs += int'(bus.cnt_down);
      loads += int'(bus.cnt_load);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_complete"}, 32'(got), 32'd1);
    if (got) begin
      if (sb.size() == 0) begin
        chk({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        got_e = sb.pop_front();
        chk({name, "_err"},   32'(bus.err),   32'(got_e.is_err));
        chk({name, "_done"},  32'(bus.done),  32'(!got_e.is_err));
        chk({name, "_steps"}, 32'(bus.steps), 32'(got_e.steps));
        chk({name, "_value"}, 32'(bus.cnt_value), 32'(got_e.value));
      end
      @(posedge clk); #1;
      chk({name, "_pulse_drop"}, 32'(bus.done | bus.err), 32'd0);
      chk({name, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    int lat, ups, downs, loads, pulses;
    checks = 0; errors = 0;
    ctr = 5'd0; stuck_en = 1'b0; stuck_val = 5'd0; force_high = 1'b0;
    bus.req_valid = 1'b0; bus.req_load = 1'b0;
    bus.req_base = 5'd0; bus.req_target = 5'd0;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_cmds", {28'd0, bus.cnt_load, bus.cnt_up, bus.cnt_down, 1'b0}, 32'd0);
    chk("rst_cnt_in", 32'(bus.cnt_in), 32'd0);
    chk("rst_status", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    chk("rst_steps", 32'(bus.steps), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // load and count up: 10 -> 14
    run_req("load_up", 1'b1, 5'd10, 5'd14, 1'b0, 4, 5'd14, lat, ups, downs, loads);
    chk("load_up_latency", 32'(lat), 32'd6);
    chk("load_up_loads", 32'(loads), 32'd1);
    chk("load_up_ups", 32'(ups), 32'd4);
    chk("load_up_downs", 32'(downs), 32'd0);

    // count down to the floor from 14
    run_req("down_floor", 1'b0, 5'd0, 5'd0, 1'b0, 14, 5'd0, lat, ups, downs, loads);
    chk("down_floor_downs", 32'(downs), 32'd14);
    chk("down_floor_latency", 32'(lat), 32'd15);
    chk("down_floor_low", 32'(bus.cnt_low), 32'd1);

    // count up to the ceiling from 0
    run_req("up_ceil", 1'b0, 5'd0, 5'd31, 1'b0, 31, 5'd31, lat, ups, downs, loads);
    chk("up_ceil_ups", 32'(ups), 32'd31);
    chk("up_ceil_high", 32'(bus.cnt_high), 32'd1);

    // zero-step request
    run_req("zero", 1'b1, 5'd9, 5'd9, 1'b0, 0, 5'd9, lat, ups, downs, loads);
    chk("zero_updown", 32'(ups + downs), 32'd0);

    // stuck counter runs into the timeout
    stuck_en = 1'b1; stuck_val = 5'd3;
    run_req("stuck", 1'b0, 5'd0, 5'd20, 1'b1, 40, 5'd3, lat, ups, downs, loads);

    // forced high flag faults on the first step edge
    stuck_val = 5'd5; force_high = 1'b1;
    run_req("forced_high", 1'b0, 5'd0, 5'd20, 1'b1, 0, 5'd5, lat, ups, downs, loads);
    chk("forced_high_latency", 32'(lat), 32'd1);
    stuck_en = 1'b0; force_high = 1'b0;

    // reset in the middle of a 0 -> 20 run
    bus.req_valid = 1'b1; bus.req_load = 1'b1;
    bus.req_base = 5'd0; bus.req_target = 5'd20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrun_up_before", 32'(bus.cnt_up), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_cmds_drop", {29'd0, bus.cnt_load, bus.cnt_up, bus.cnt_down}, 32'd0);
    chk("midrun_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      pulses += int'(bus.done) + int'(bus.err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    pulses += int'(bus.done) + int'(bus.err);
    chk("midrun_no_pulse", 32'(pulses), 32'd0);
    chk("midrun_ready", 32'(bus.req_ready), 32'd1);
    run_req("after_rst", 1'b1, 5'd20, 5'd17, 1'b0, 3, 5'd17, lat, ups, downs, loads);
    chk("after_rst_downs", 32'(downs), 32'd3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_dn_counter_driver.md
# up_dn_counter_driver

Command-side controller for the 5-bit saturating up/down counter (load beats down, down beats up, saturates at 0 and 31, high/low flags). It accepts a move request, optionally loads a base value, then issues single-step up or down commands until the counter output equals the requested target. It reports done, error and the number of steps taken. It sits between a request source and one counter instance, and is the initiator for that counter's load/up/down interface.

## Interface
- WIDTH, 5, counter width; must match the attached counter
- TIMEOUT, 40, maximum STEP cycles per request before error
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE with rst low; a request is accepted on an edge where req_valid && req_ready
- req_load  in  1  1 = load req_base before stepping; 0 = step from the current counter value
- req_base  in  WIDTH  load value (ignored when req_load=0)
- req_target  in  WIDTH  final counter value
- cnt_in  out  WIDTH  to counter `in`
- cnt_load  out  1  to counter `load`
- cnt_up  out  1  to counter `up`
- cnt_down  out  1  to counter `down`
- cnt_value  in  WIDTH  from counter `counter`
- cnt_high, cnt_low  in  1  from counter `high` and `low` flags
- busy  out  1  high in LOAD, STEP, DONE and ERR
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on failure
- steps  out  6  step commands issued for the current or last request; saturates at 63

## Operation
- States: IDLE, LOAD, STEP, DONE, ERR.
- Request capture on accept: target_r, base_r and load_r are registered, steps is cleared to 0 and the timer is cleared to 0.
- IDLE -> LOAD on accept when req_load=1; IDLE -> STEP when req_load=0.
- LOAD: cnt_load=1, cnt_in=base_r, cnt_up=0, cnt_down=0. After one cycle -> STEP.
- STEP: outputs are combinational from cnt_value and target_r.
  - cnt_up = (cnt_value < target_r); cnt_down = (cnt_value > target_r); never both high.
  - cnt_load=0. cnt_in holds base_r; the value is don't-care.
  - Each cycle with cnt_up or cnt_down high increments steps and the timer.
  - cnt_value == target_r -> DONE.
  - Error -> ERR when either holds:
    - cnt_up needed while cnt_high=1;
    - cnt_down needed while cnt_low=1;
    - timer == TIMEOUT.
  - On an error edge, equality is checked first; success wins.
- DONE: done=1 for one cycle, then -> IDLE.
- ERR: err=1 for one cycle, then -> IDLE.
- In DONE and ERR all cnt_* command outputs are 0.
- In IDLE, cnt_load, cnt_up and cnt_down are 0.
- Target equal to the start value: zero steps, done still pulses.
- A new request is not accepted before returning to IDLE; there is no queueing.

## Timing
- Reset values:
  - state IDLE; req_ready=0 while rst high;
  - cnt_in=0, cnt_load=0, cnt_up=0, cnt_down=0;
  - busy=0, done=0, err=0, steps=0.
- req_ready goes to 1 in the first cycle after rst falls.
- Reset mid-operation: commands drop immediately (asynchronous). The counter keeps its current value. No done or err pulse is issued.
- Latency with load, accept edge E0, n = |target − base|:
  - LOAD cycle follows E0; counter = base after E1.
  - Counter moves at edges E2..E(n+1).
  - Equality is seen in the cycle after E(n+1).
  - done is high in the cycle after E(n+2); req_ready returns after E(n+3).
- Without load: subtract one cycle, and n is measured from cnt_value at E0.
- done, err, busy and req_ready are decoded from registered state. cnt_up and cnt_down depend combinationally on cnt_value, so the counter must present a registered output.

## Test plan
- Load and count up: reset, then request load=1, base=10, target=14 -> cnt_load high for 1 cycle; 4 cycles of cnt_up; done pulses 6 cycles after accept; counter=14; steps=4.
- Count down to floor without load: counter at 14, request load=0, target=0 -> 14 cycles of cnt_down; done; counter=0 and low=1; steps=14.
- Ceiling: counter at 0, request load=0, target=31 -> 31 cycles of cnt_up; done; counter=31 and high=1; steps=31.
- Zero-step: request load=1, base=9, target=9 -> no up/down cycles; done; steps=0.
- Error:
  - Stuck counter: tie cnt_value to 3, request target=20 -> err pulses after TIMEOUT=40 STEP cycles; steps=40; done never pulses.
  - Forced high: force cnt_high=1 with cnt_value=5 and target=20 -> err on the next edge.
- Reset mid-run: assert rst during STEP of a 0->20 request -> command outputs go to 0 immediately; no done or err; req_ready=1 one cycle after release; a fresh request completes normally.
